// File: rtl/load_store_unit.sv
// RV64 load/store sequencer: accepts one access from IDLE, reads the containing
// doubleword when needed, extends loads or merges partial stores, and pulses done.
module load_store_unit #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WRITE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  logic [1:0]  state;
  logic [2:0]  lat_cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        err_q;

  logic        req_bad;
  logic [63:0] load_lane;
  logic [63:0] load_val;
  logic [63:0] lane_mask;
  logic [63:0] merged;

  // Request check on the live inputs so the error path can skip straight to DONE.
  always_comb begin
    req_bad = we ? funct3[2] : (funct3 == 3'b111);
    unique case (funct3[1:0])
      2'b01:   if (addr[0])        req_bad = 1'b1;
      2'b10:   if (addr[1:0] != '0) req_bad = 1'b1;
      2'b11:   if (addr[2:0] != '0) req_bad = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_lane = mem_rdata >> {addr_q[2:0], 3'b000};
    unique case (funct3_q)
      3'b000:  load_val = {{56{load_lane[7]}},  load_lane[7:0]};
      3'b001:  load_val = {{48{load_lane[15]}}, load_lane[15:0]};
      3'b010:  load_val = {{32{load_lane[31]}}, load_lane[31:0]};
      3'b100:  load_val = {56'd0, load_lane[7:0]};
      3'b101:  load_val = {48'd0, load_lane[15:0]};
      3'b110:  load_val = {32'd0, load_lane[31:0]};
      default: load_val = load_lane;
    endcase
  end

  // Partial store: replace only the addressed byte lanes of the fetched doubleword.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
    lane_mask = lane_mask << {addr_q[2:0], 3'b000};
    merged    = (mem_rdata & ~lane_mask) | ((wdata_q << {addr_q[2:0], 3'b000}) & lane_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q     <= we;
            funct3_q <= funct3;
            addr_q   <= addr;
            wdata_q  <= wdata;
            err_q    <= req_bad;
            lat_cnt  <= LAT_LAST;
            if (req_bad) begin
              state <= DONE;
            end else if (we && funct3[1:0] == 2'b11) begin
              mem_wdata <= wdata;
              state     <= WRITE;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
            if (we_q) begin
              mem_wdata <= merged;
              state     <= WRITE;
            end else begin
              rdata <= load_val;
              state <= DONE;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        WRITE:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = done & err_q;
  assign mem_wr   = (state == WRITE);
  assign mem_addr = {addr_q[63:3], 3'b000};

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory reference model,
// directed cases plus random accesses, monitor pops expectations on done/mem_wr.
module tb_load_store_unit;

  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, err, mem_wr;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // DUT-side memory: 32 doublewords, loaded from init_dw while init_mem is high.
  logic [63:0] tbmem   [0:31];
  logic [63:0] init_dw [0:31];
  logic        init_mem = 1'b1;
  assign mem_rdata = tbmem[mem_addr[7:3]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) tbmem[i] <= init_dw[i];
    end else if (mem_wr) begin
      tbmem[mem_addr[7:3]] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic err; logic [63:0] rdata; logic [63:0] dw; } done_t;
  typedef struct { int cyc; logic [63:0] dw; logic [63:0] data; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  int errors = 0;
  int checks = 0;
  logic end_chk = 1'b0;
  logic end_done = 1'b0;
  int busy_run = 0;

  // Reference memory as plain bytes, little-endian.
  logic [7:0]  refb [0:255];
  logic [63:0] exp_rdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      chk("rst_mem_wdata", mem_wdata, 64'd0);
      busy_run = 0;
    end else begin
      if (err && !done) chk("err_without_done", 64'(err), 64'd0);
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run == 64) chk("busy_timeout", 64'(busy), 64'd0);
      if (mem_wr) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 64'(mem_wr), 64'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_cycle", 64'(cyc), 64'(w.cyc));
          chk("write_addr", mem_addr, w.dw);
          chk("write_data", mem_wdata, w.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          done_t e;
          e = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("done_err", 64'(err), 64'(e.err));
          chk("done_rdata", rdata, e.rdata);
          chk("done_mem_addr", mem_addr, e.dw);
        end
      end
      if (end_chk && !end_done) begin
        chk("pending_expectations", 64'(dq.size() + wq.size()), 64'd0);
        end_done = 1'b1;
      end
    end
  end

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    int unsigned size;
    int ab;
    logic [63:0] v;
    size = 1 << f3[1:0];
    ab   = int'(a[7:0]);
    v    = '0;
    for (int j = 0; j < int'(size); j++) v |= 64'(refb[ab + j]) << (8 * j);
    if (!f3[2] && size < 8 && v[8 * size - 1]) v |= ~64'd0 << (8 * size);
    return v;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  // Called at a negedge with the DUT idle; pushes expectations, pulses req one cycle.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input bit commit, input bit ovr,
                       input logic [63:0] ovr_val, input bit wait_end);
    int unsigned size;
    bit bad;
    int c, ab, base, wc;
    logic [7:0] tmp [0:7];
    logic [63:0] dw, nd, v;
    size = 1 << f3[1:0];
    bad  = w ? f3[2] : (f3 == 3'b111);
    if (!bad && (int'(a[2:0]) % int'(size)) != 0) bad = 1'b1;
    dw   = {a[63:3], 3'b000};
    c    = cyc;
    ab   = int'(a[7:0]);
    base = ab & ~7;
    if (bad) begin
      dq.push_back('{c + 1, 1'b1, exp_rdata, dw});
    end else if (!w) begin
      v = ovr ? ovr_val : model_load(f3, a);
      exp_rdata = v;
      dq.push_back('{c + 1 + int'(L), 1'b0, v, dw});
    end else begin
      for (int k = 0; k < 8; k++) tmp[k] = refb[base + k];
      for (int j = 0; j < int'(size); j++) tmp[(ab & 7) + j] = wd[8 * j +: 8];
      nd = '0;
      for (int k = 0; k < 8; k++) nd |= 64'(tmp[k]) << (8 * k);
      if (commit) for (int k = 0; k < 8; k++) refb[base + k] = tmp[k];
      if (ovr) nd = ovr_val;
      wc = (size == 8) ? c + 1 : c + 1 + int'(L);
      wq.push_back('{wc, dw, nd});
      dq.push_back('{wc + 1, 1'b0, exp_rdata, dw});
    end
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0; we = $urandom_range(0, 1); funct3 = 3'($urandom);
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (wait_end) wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) refb[i] = 8'($urandom);
    for (int k = 0; k < 8; k++) refb[64 + k] = 8'(8'h11 * (k + 1));
    for (int i = 0; i < 32; i++) begin
      init_dw[i] = '0;
      for (int k = 0; k < 8; k++) init_dw[i] |= 64'(refb[8 * i + k]) << (8 * k);
    end
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 3'b011, 64'h40, '0, 1'b1, 1'b1, 64'h8877665544332211, 1'b1);
    issue(1'b0, 3'b000, 64'h47, '0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFF88, 1'b1);
    issue(1'b0, 3'b100, 64'h47, '0, 1'b1, 1'b1, 64'h88, 1'b1);
    issue(1'b0, 3'b001, 64'h46, '0, 1'b1, 1'b1, 64'hFFFFFFFFFFFF8877, 1'b1);
    issue(1'b0, 3'b110, 64'h44, '0, 1'b1, 1'b1, 64'h88776655, 1'b1);
    issue(1'b1, 3'b000, 64'h41, 64'hAB, 1'b1, 1'b1, 64'h887766554433AB11, 1'b1);
    issue(1'b1, 3'b011, 64'h48, 64'h1234, 1'b1, 1'b0, '0, 1'b1);
    issue(1'b0, 3'b010, 64'h42, '0, 1'b1, 1'b0, '0, 1'b1);
    issue(1'b1, 3'b101, 64'h40, 64'h55, 1'b1, 1'b0, '0, 1'b1);
    issue(1'b0, 3'b111, 64'h40, '0, 1'b1, 1'b0, '0, 1'b1);

    // req held for 10 cycles: a new access starts each time the FSM returns to IDLE.
    begin
      int c0;
      logic [63:0] v;
      c0 = cyc;
      v  = model_load(3'b011, 64'h40);
      exp_rdata = v;
      for (int k = 0; k * int'(L + 2) < 10; k++)
        dq.push_back('{c0 + k * int'(L + 2) + 1 + int'(L), 1'b0, v, 64'h40});
      req = 1'b1; we = 1'b0; funct3 = 3'b011; addr = 64'h40;
      repeat (10) @(negedge clk);
      req = 1'b0;
      wait_idle();
    end

    // Reset while a byte store waits on its read: no write, memory untouched.
    @(negedge clk);
    issue(1'b1, 3'b000, 64'h43, 64'h5A, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    dq.delete();
    wq.delete();
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'b011, 64'h40, '0, 1'b1, 1'b0, '0, 1'b1);

    for (int n = 0; n < 200; n++) begin
      logic w;
      logic [2:0] f3;
      logic [63:0] a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      issue(w, f3, a, {$urandom, $urandom}, 1'b1, 1'b0, '0, 1'b1);
    end

    repeat (3) @(negedge clk);
    end_chk = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
